// File: rtl/pmul_arbiter.sv
// Round-robin arbiter/sequencer sharing one SM2 point-multiplication engine among N_REQ requesters.
// Optional watchdog on the RUN state is enabled by defining PMUL_ARB_WATCHDOG_EN.
module pmul_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [256*N_REQ-1:0]   req_k,
  input  logic [256*N_REQ-1:0]   req_x,
  input  logic [256*N_REQ-1:0]   req_y,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [255:0]           rsp_x,
  output logic [255:0]           rsp_y,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   eng_rst_n,
  output logic [255:0]           eng_k,
  output logic [255:0]           eng_x,
  output logic [255:0]           eng_y,
  input  logic [255:0]           eng_xo,
  input  logic [255:0]           eng_yo,
  input  logic                   eng_done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, sel;
  logic [PW:0]      sum;
  logic             found;
  logic [N_REQ-1:0] gnt_d, rsp_valid_d;
  logic [255:0]     rsp_x_d, rsp_y_d;
  logic [255:0]     eng_k_d, eng_x_d, eng_y_d;
  logic [255:0]     sel_k, sel_x, sel_y;
  logic             busy_d, eng_rst_n_d;

`ifdef PMUL_ARB_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] wd_q, wd_d;
  logic        rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT_CYC);
  assign rsp_err        = 1'b0;
`endif

  // Round-robin search: first requester at or after ptr+1, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    sum   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      if (!found && req[sum[PW-1:0]]) begin
        found = 1'b1;
        sel   = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_k = '0;
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == PW'(i)) begin
        sel_k = req_k[256*i +: 256];
        sel_x = req_x[256*i +: 256];
        sel_y = req_y[256*i +: 256];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt;
    rsp_valid_d = '0;
    rsp_x_d     = rsp_x;
    rsp_y_d     = rsp_y;
    busy_d      = busy;
    eng_rst_n_d = eng_rst_n;
    eng_k_d     = eng_k;
    eng_x_d     = eng_x;
    eng_y_d     = eng_y;
`ifdef PMUL_ARB_WATCHDOG_EN
    wd_d        = wd_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        eng_rst_n_d = 1'b0;
        if (found) begin
          ptr_d   = sel;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
          eng_k_d = sel_k;
          eng_x_d = sel_x;
          eng_y_d = sel_y;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Engine has seen one reset cycle with stable operands; release it.
        eng_rst_n_d = 1'b1;
`ifdef PMUL_ARB_WATCHDOG_EN
        wd_d        = '0;
`endif
        state_d     = RUN;
      end
      RUN: begin
        if (eng_done) begin
          rsp_x_d     = eng_xo;
          rsp_y_d     = eng_yo;
          rsp_valid_d = gnt;
          eng_rst_n_d = 1'b0;
          state_d     = DONE;
`ifdef PMUL_ARB_WATCHDOG_EN
          rsp_err_d   = 1'b0;
        end else if (wd_q == WD_LAST) begin
          rsp_x_d     = '0;
          rsp_y_d     = '0;
          rsp_valid_d = gnt;
          rsp_err_d   = 1'b1;
          eng_rst_n_d = 1'b0;
          state_d     = DONE;
        end else begin
          wd_d        = wd_q + 32'd1;
`endif
        end
      end
      DONE: begin
        gnt_d       = '0;
        busy_d      = 1'b0;
        eng_rst_n_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= PW'(N_REQ - 1);
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_x     <= '0;
      rsp_y     <= '0;
      busy      <= 1'b0;
      eng_rst_n <= 1'b0;
      eng_k     <= '0;
      eng_x     <= '0;
      eng_y     <= '0;
`ifdef PMUL_ARB_WATCHDOG_EN
      wd_q      <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_x     <= rsp_x_d;
      rsp_y     <= rsp_y_d;
      busy      <= busy_d;
      eng_rst_n <= eng_rst_n_d;
      eng_k     <= eng_k_d;
      eng_x     <= eng_x_d;
      eng_y     <= eng_y_d;
`ifdef PMUL_ARB_WATCHDOG_EN
      wd_q      <= wd_d;
      rsp_err_q <= rsp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_pmul_arbiter.sv
// Directed bench for pmul_arbiter with a behavioural engine (latency 20, xo=k^x, yo=k^y).
module tb_pmul_arbiter;

  localparam int N   = 4;
  localparam int L   = 20;
  localparam int TMO = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [256*N-1:0] req_k, req_x, req_y;
  logic [N-1:0]     gnt, rsp_valid;
  logic [255:0]     rsp_x, rsp_y;
  logic             rsp_err, busy, eng_rst_n;
  logic [255:0]     eng_k, eng_x, eng_y, eng_xo, eng_yo;
  logic             eng_done;

  logic [255:0] k_v [N];
  logic [255:0] x_v [N];
  logic [255:0] y_v [N];
  logic         force_done = 1'b0;
  logic         stall = 1'b0;
  int           cnt = 0;
  int           vectors = 0;
  int           miscompares = 0;
  logic         seen_valid;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_k[256*g +: 256] = k_v[g];
    assign req_x[256*g +: 256] = x_v[g];
    assign req_y[256*g +: 256] = y_v[g];
  end

  pmul_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_k(req_k), .req_x(req_x), .req_y(req_y),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .rsp_err(rsp_err), .busy(busy), .eng_rst_n(eng_rst_n),
    .eng_k(eng_k), .eng_x(eng_x), .eng_y(eng_y),
    .eng_xo(eng_xo), .eng_yo(eng_yo), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  // Behavioural engine: counts run cycles since reset release.
  always @(posedge clk) cnt <= eng_rst_n ? cnt + 1 : 0;
  assign eng_done = force_done | (!stall && eng_rst_n && (cnt >= L));
  assign eng_xo   = eng_k ^ eng_x;
  assign eng_yo   = eng_k ^ eng_y;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Entered in cycle 0 of a job (IDLE with req set); returns in the next cycle 0.
  task automatic serve(input int idx, input bit keep);
    step();
    check($sformatf("gnt_job%0d", idx), 256'(gnt), 256'(onehot(idx)));
    repeat (21) step();
    check($sformatf("rsp_valid_early%0d", idx), 256'(rsp_valid), 256'(0));
    step();
    check($sformatf("rsp_valid_job%0d", idx), 256'(rsp_valid), 256'(onehot(idx)));
    check($sformatf("rsp_x_job%0d", idx), rsp_x, k_v[idx] ^ x_v[idx]);
    check($sformatf("rsp_y_job%0d", idx), rsp_y, k_v[idx] ^ y_v[idx]);
    check($sformatf("rsp_err_job%0d", idx), 256'(rsp_err), 256'(0));
    if (!keep) req[idx] = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      k_v[i] = {64'hC0DE_0000_0000_0000 + 64'(i), 192'h0} | 256'(i * 37 + 11);
      x_v[i] = {128'h0, 128'hFACE_0000_0000_1234 + 128'(i)};
      y_v[i] = {192'h0, 64'h0BAD_F00D_0000_0000 + 64'(i * 5)};
    end
    k_v[1] = 256'd5;
    x_v[1] = 256'd3;
    y_v[1] = 256'd6;

    // Reset values
    #2;
    check("rst_gnt", 256'(gnt), 256'(0));
    check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_eng_rst_n", 256'(eng_rst_n), 256'(0));
    check("rst_eng_k", eng_k, 256'(0));
    check("rst_rsp_x", rsp_x, 256'(0));
    do_reset();

    // Single job, requester 1
    req = 4'b0010;
    step();
    check("single_gnt", 256'(gnt), 256'(4'b0010));
    check("single_busy_c1", 256'(busy), 256'(1));
    check("single_eng_rst_n_c1", 256'(eng_rst_n), 256'(0));
    check("single_eng_k", eng_k, 256'd5);
    step();
    check("single_eng_rst_n_c2", 256'(eng_rst_n), 256'(1));
    k_v[1] = 256'd99;
    repeat (20) step();
    check("single_rsp_valid_c22", 256'(rsp_valid), 256'(0));
    step();
    check("single_rsp_valid_c23", 256'(rsp_valid), 256'(4'b0010));
    check("single_rsp_x", rsp_x, 256'd6);
    check("single_rsp_y", rsp_y, 256'd3);
    check("single_rsp_err", 256'(rsp_err), 256'(0));
    req = '0;
    step();
    check("single_busy_c24", 256'(busy), 256'(0));
    check("single_rsp_valid_c24", 256'(rsp_valid), 256'(0));
    check("single_rsp_x_hold", rsp_x, 256'd6);
    k_v[1] = 256'd5;

    // Rotation after reset, twice
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) serve(i, 1'b0);
    check("rot_idle_busy", 256'(busy), 256'(0));
    req = 4'b1111;
    for (int i = 0; i < N; i++) serve(i, 1'b0);

    // Fairness: 0 and 2 keep requesting, 1 and 3 idle
    req = 4'b0101;
    serve(0, 1'b1);
    serve(2, 1'b1);
    serve(0, 1'b1);
    serve(2, 1'b1);
    req = '0;
    step();

    // Reset in the middle of RUN
    req = 4'b0001;
    repeat (10) step();
    check("midrun_busy_before", 256'(busy), 256'(1));
    rst_n = 1'b0;
    #1;
    check("midrun_gnt", 256'(gnt), 256'(0));
    check("midrun_busy", 256'(busy), 256'(0));
    check("midrun_eng_rst_n", 256'(eng_rst_n), 256'(0));
    check("midrun_rsp_x", rsp_x, 256'(0));
    check("midrun_eng_k", eng_k, 256'(0));
    req = '0;
    step();
    step();
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      seen_valid = seen_valid | (|rsp_valid);
    end
    check("midrun_no_rsp", 256'(seen_valid), 256'(0));
    check("midrun_idle_busy", 256'(busy), 256'(0));
    check("midrun_idle_eng_rst_n", 256'(eng_rst_n), 256'(0));

    // Spurious done in IDLE and LOAD
    force_done = 1'b1;
    step();
    check("spur_idle_busy", 256'(busy), 256'(0));
    check("spur_idle_rsp_valid", 256'(rsp_valid), 256'(0));
    req = 4'b0100;
    step();
    check("spur_gnt", 256'(gnt), 256'(4'b0100));
    step();
    force_done = 1'b0;
    check("spur_load_rsp_valid", 256'(rsp_valid), 256'(0));
    check("spur_load_busy", 256'(busy), 256'(1));
    repeat (20) step();
    check("spur_rsp_valid_c22", 256'(rsp_valid), 256'(0));
    step();
    check("spur_rsp_valid_c23", 256'(rsp_valid), 256'(4'b0100));
    check("spur_rsp_x", rsp_x, k_v[2] ^ x_v[2]);
    req = '0;
    step();

    // Stalled engine
    stall = 1'b1;
    req = 4'b0001;
`ifdef PMUL_ARB_WATCHDOG_EN
    repeat (65) step();
    check("wd_rsp_valid_c65", 256'(rsp_valid), 256'(0));
    step();
    check("wd_rsp_valid_c66", 256'(rsp_valid), 256'(4'b0001));
    check("wd_rsp_err", 256'(rsp_err), 256'(1));
    check("wd_rsp_x", rsp_x, 256'(0));
    check("wd_rsp_y", rsp_y, 256'(0));
    check("wd_eng_rst_n", 256'(eng_rst_n), 256'(0));
    req = '0;
    step();
    check("wd_busy_after", 256'(busy), 256'(0));
`else
    repeat (1000) step();
    check("nowd_busy_c1000", 256'(busy), 256'(1));
    check("nowd_rsp_valid_c1000", 256'(rsp_valid), 256'(0));
    check("nowd_rsp_err", 256'(rsp_err), 256'(0));
    check("nowd_eng_rst_n", 256'(eng_rst_n), 256'(1));
`endif
    stall = 1'b0;
    do_reset();
    check("final_busy", 256'(busy), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
